// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and sizing helper for the skid chain
// Purpose: default payload width, maximum chain depth, and the occupancy
//          counter width function used by pipeline_skid_chain.
// Ports:   none (package).
package pipeline_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_STAGES    = 8;

  // Counter must represent 0..2*stages inclusive (two entries per slot).
  function automatic int cnt_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipeline_skid_slot.sv
// rtl/pipeline_skid_slot.sv - one main + skid register pair with valid/ready
// Purpose: a two-entry register slice whose in_ready comes straight from a
//          flop, so no ready path crosses the slot combinationally.
// Ports:   clk, reset (sync, active-high), flush (sync clear),
//          in_valid/in_ready/in_data   upstream handshake,
//          out_valid/out_ready/out_data downstream handshake (from main reg).
module pipeline_skid_slot
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;

  // Ready is only the skid flag: the slot can always absorb one more entry
  // while the skid register is free, whatever the downstream does.
  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (!main_valid || out_ready) begin
      // Main is free this edge: the older skid entry goes first.
      main_valid <= skid_valid || in_fire;
      skid_valid <= 1'b0;
      if (skid_valid) begin
        main_data <= skid_data;
      end else if (in_fire) begin
        main_data <= in_data;
      end
    end else if (in_fire) begin
      // Main is stalled: park the accepted entry in skid.
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/pipeline_skid_chain.sv
// rtl/pipeline_skid_chain.sv - STAGES chained skid slots with occupancy count
// Purpose: registered valid/ready pipeline of depth STAGES, capacity
//          2*STAGES, with flush and a registered occupancy counter.
// Ports:   clk, reset (sync, active-high, wins over flush), flush,
//          in_valid/in_ready/in_data   upstream handshake,
//          out_valid/out_ready/out_data downstream handshake,
//          occupancy                    number of entries currently held.
module pipeline_skid_chain
  import pipeline_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = 1,
  localparam int CNT_W = cnt_width(STAGES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Link i feeds slot i; link STAGES is the chain output.
  logic             link_valid [STAGES+1];
  logic             link_ready [STAGES+1];
  logic [WIDTH-1:0] link_data  [STAGES+1];

  assign link_valid[0]      = in_valid;
  assign link_data[0]       = in_data;
  assign in_ready           = link_ready[0];
  assign out_valid          = link_valid[STAGES];
  assign out_data           = link_data[STAGES];
  assign link_ready[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    pipeline_skid_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (link_valid[i]),
      .in_ready (link_ready[i]),
      .in_data  (link_data[i]),
      .out_valid(link_valid[i+1]),
      .out_ready(link_ready[i+1]),
      .out_data (link_data[i+1])
    );
  end

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Internal slot-to-slot moves leave the total unchanged, so only the two
  // chain ports affect the count.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + ONE;
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_skid_chain.sv
// tb/tb_pipeline_skid_chain.sv - self-checking bench for pipeline_skid_chain
module tb_pipeline_skid_chain;

  localparam int W  = 32;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    occupancy;

  logic          d1_in_valid;
  logic          d1_in_ready;
  logic [7:0]    d1_in_data;
  logic          d1_out_valid;
  logic          d1_out_ready;
  logic [7:0]    d1_out_data;
  logic [1:0]    d1_occupancy;
  logic          d1_flush;

  always #5 clk = ~clk;

  pipeline_skid_chain #(.WIDTH(W), .STAGES(ST)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  pipeline_skid_chain #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .flush    (d1_flush),
    .in_valid (d1_in_valid),
    .in_ready (d1_in_ready),
    .in_data  (d1_in_data),
    .out_valid(d1_out_valid),
    .out_ready(d1_out_ready),
    .out_data (d1_out_data),
    .occupancy(d1_occupancy)
  );

  int           vectors     = 0;
  int           miscompares = 0;
  int           cyc         = 0;
  int           in_acc      = 0;
  int           out_cnt     = 0;
  int           peak_occ    = 0;
  bit           lat_on      = 1'b0;
  logic [W-1:0] q  [$];
  int           qc [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample/compare at negedge, advance the scoreboard at posedge.
  task automatic tick();
    logic in_fire;
    logic out_fire;
    @(negedge clk);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (!reset) begin
      check("occupancy", 64'(occupancy), 64'(q.size()));
      if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
      if (q.size() == 0) check("empty_out_valid", 64'(out_valid), 64'(0));
      if (q.size() == 2 * ST) check("full_in_ready", 64'(in_ready), 64'(0));
      if (out_valid && q.size() > 0) begin
        check("out_data", 64'(out_data), 64'(q[0]));
        if (lat_on && out_fire) check("latency", 64'(cyc - qc[0]), 64'(ST));
      end
    end
    @(posedge clk);
    if (reset || flush) begin
      q.delete();
      qc.delete();
    end else begin
      if (out_fire && q.size() > 0) begin
        void'(q.pop_front());
        void'(qc.pop_front());
        out_cnt++;
      end
      if (in_fire) begin
        q.push_back(in_data);
        qc.push_back(cyc);
        in_acc++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (q.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_complete", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int acc0;
    int out0;
    int guard;
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    d1_in_valid = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0; d1_flush = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));

    // Three back-to-back words, downstream always ready
    lat_on = 1'b1; out_ready = 1'b1; peak_occ = 0; out0 = out_cnt;
    in_valid = 1'b1;
    in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_data = 32'h33; tick();
    in_valid = 1'b0; in_data = '0;
    drain(10);
    check("stream_out_count", 64'(out_cnt - out0), 64'(3));
    check("stream_peak_occ", 64'(peak_occ), 64'(2));
    lat_on = 1'b0;

    // Fill to capacity with downstream stalled
    out_ready = 1'b0; acc0 = in_acc; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h100 + i;
      tick();
    end
    check("fill_accepted", 64'(in_acc - acc0), 64'(4));
    check("fill_in_ready", 64'(in_ready), 64'(0));
    check("fill_occupancy", 64'(occupancy), 64'(4));
    in_valid = 1'b0; out_ready = 1'b1; out0 = out_cnt;
    drain(20);
    check("fill_drained", 64'(out_cnt - out0), 64'(4));
    check("fill_in_ready_back", 64'(in_ready), 64'(1));

    // Random traffic, 1000 words
    acc0 = in_acc; guard = 0;
    while (((in_acc - acc0) < 1000 || q.size() > 0) && guard < 20000) begin
      in_valid  = ((in_acc - acc0) < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
      guard++;
    end
    check("random_sent", 64'(in_acc - acc0), 64'(1000));
    check("random_drained", 64'(q.size()), 64'(0));

    // Flush with occupancy 3 and a word offered in the flush cycle
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h200 + i;
      tick();
    end
    check("pre_flush_occ", 64'(occupancy), 64'(3));
    in_data = 32'hAA; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_data = '0;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_occupancy", 64'(occupancy), 64'(0));
    check("flush_out_data", 64'(out_data), 64'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Reset and flush together mid-stream, then a single word
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h301; tick();
    in_data = 32'h302; tick();
    reset = 1'b1; flush = 1'b1; in_data = 32'h303;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    check("rf_in_ready", 64'(in_ready), 64'(1));
    check("rf_out_valid", 64'(out_valid), 64'(0));
    check("rf_out_data", 64'(out_data), 64'(0));
    check("rf_occupancy", 64'(occupancy), 64'(0));
    lat_on = 1'b1; out_ready = 1'b1; out0 = out_cnt;
    in_valid = 1'b1; in_data = 32'h5A; tick();
    in_valid = 1'b0; in_data = '0;
    drain(10);
    check("rf_single_out", 64'(out_cnt - out0), 64'(1));
    lat_on = 1'b0;

    // STAGES=1, WIDTH=8 stall retention
    d1_out_ready = 1'b0; d1_in_valid = 1'b1; d1_in_data = 8'h7E;
    tick();
    d1_in_valid = 1'b0; d1_in_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_out_valid", 64'(d1_out_valid), 64'(1));
      check("stall_out_data", 64'(d1_out_data), 64'(8'h7E));
    end
    d1_out_ready = 1'b1;
    tick();
    check("stall_release_valid", 64'(d1_out_valid), 64'(0));
    check("stall_release_occ", 64'(d1_occupancy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_chain.md
PIPELINE_SKID_CHAIN -- requirements
Module: pipeline_skid_chain

Interface
REQ-001 Parameter WIDTH, default 32, payload bits carried per transfer; legal range 1..256.
REQ-002 Parameter STAGES, default 1, number of chained register slots; legal range 1..8.
REQ-003 Local parameter CNT_W = $clog2(2*STAGES+1), the occupancy counter width.
REQ-004 clk  input  1  the single clock; all state changes on its posedge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 flush  input  1  synchronous, active-high pipeline clear (bubble insert).
REQ-007 in_valid  input  1  upstream offers in_data this cycle.
REQ-008 in_ready  output  1  chain can accept; registered, depends only on state.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  WIDTH  head payload.
REQ-013 occupancy  output  CNT_W  count of valid entries held in the chain.

Function
REQ-014 A transfer occurs on any cycle where valid and ready are both high at that port; there is no other acceptance condition.
REQ-015 Each slot holds one main register and one skid register, each with its own valid bit; slot capacity is 2, chain capacity is 2*STAGES.
REQ-016 Slot in_ready is the inverse of the slot skid valid bit.
REQ-017 When main is empty or the downstream is ready, main loads: skid contents if skid is valid, else the accepted input; the skid valid bit clears.
REQ-018 When main is full and the downstream is not ready, an accepted input loads into skid and sets skid valid.
REQ-019 Unstalled latency: in_data accepted at cycle N appears on out_data with out_valid at cycle N+STAGES.
REQ-020 Unstalled throughput: one transfer per cycle.
REQ-021 Ordering: strict FIFO; there is no loss or duplication without flush.
REQ-022 out_valid and out_data are driven directly from the last slot's main register.
REQ-023 On flush, all valid bits clear, all data registers clear to 0, and occupancy clears to 0 at the next edge.
REQ-024 An input offered in the same cycle as flush is dropped, and an output in that cycle still counts as consumed.
REQ-025 occupancy is a registered counter: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
REQ-026 occupancy equals the popcount of all valid bits at every cycle.
REQ-027 When occupancy equals 2*STAGES, in_ready is 0.
REQ-028 When occupancy equals 0, out_valid is 0.
REQ-029 Holding out_ready low while full retains all data unchanged, indefinitely.
REQ-030 out_data is stable while out_valid=1 and out_ready=0.

Reset
REQ-031 reset takes priority over flush and all handshakes.
REQ-032 On reset, all valid bits clear, all data registers clear to 0, and occupancy clears to 0.
REQ-033 On the cycle after reset, in_ready=1, out_valid=0, out_data=0, and occupancy=0.
REQ-034 A reset asserted mid-stream discards all held entries, with no partial state retained.

Structure
REQ-035 A shared package, pipeline_pkg, holds the default WIDTH, the maximum STAGES, and a function computing CNT_W.
REQ-036 One sub-module, pipeline_skid_slot (main + skid register pair, WIDTH parameter), is instantiated STAGES times via generate and chained by valid/ready.
REQ-037 The chain contains no combinational path from out_ready to in_ready.

Verification
REQ-038 WIDTH=32, STAGES=2, out_ready=1: send 0x11,0x22,0x33 on consecutive cycles -> outputs appear 2 cycles later, back-to-back, in order, and occupancy peaks at 2.
REQ-039 STAGES=2, out_ready=0, continuous in_valid -> exactly 4 accepted, in_ready=0 after the 4th, occupancy=4; then out_ready=1 -> 4 drained in order and in_ready returns 1.
REQ-040 Random out_ready toggling with 1000 random words -> scoreboard matches exactly, and occupancy equals popcount every cycle.
REQ-041 Occupancy=3, then flush with in_valid=1 (0xAA) -> next cycle out_valid=0, occupancy=0, out_data=0, and 0xAA is never emitted.
REQ-042 reset and flush asserted together mid-stream -> reset values per REQ-033; then a single write of 0x5A emerges after STAGES cycles.
REQ-043 STAGES=1, WIDTH=8: a stalled output holding 0x7E remains 0x7E with out_valid=1 for 10 stall cycles.
